axi_lite_master: RTL

- Single-outstanding AXI-Lite initiator; the counterpart to the team's AXI-Lite slave interface.
- Accepts read/write commands on a simple valid/ready command port, drives the five AXI-Lite channels, and returns the read data and response code on a valid/ready response port.
- Used by UART-side control logic and test harnesses to access AXI-Lite register blocks.

---
 rtl/axi_lite_master.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite initiator: a valid/ready command port in, the five AXI-Lite channels out, a valid/ready response port back.
// Optional watchdog recovery is compiled in with `define AXI_LITE_MASTER_TIMEOUT_EN.
module axi_lite_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    // command port
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_we,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
    input  logic [3:0]            i_cmd_wstrb,
    // response port
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic                  o_rsp_we,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic [1:0]            o_rsp_resp,
    output logic                  o_busy,
    // write address channel
    output logic [ADDR_WIDTH-1:0] o_axi_awaddr,
    output logic                  o_axi_awvalid,
    input  logic                  i_axi_awready,
    // write data channel
    output logic [DATA_WIDTH-1:0] o_axi_wdata,
    output logic [3:0]            o_axi_wstrb,
    output logic                  o_axi_wvalid,
    input  logic                  i_axi_wready,
    // write response channel
    input  logic [1:0]            i_axi_bresp,
    input  logic                  i_axi_bvalid,
    output logic                  o_axi_bready,
    // read address channel
    output logic [ADDR_WIDTH-1:0] o_axi_araddr,
    output logic                  o_axi_arvalid,
    input  logic                  i_axi_arready,
    // read data channel
    input  logic [DATA_WIDTH-1:0] i_axi_rdata,
    input  logic [1:0]            i_axi_rresp,
    input  logic                  i_axi_rvalid,
    output logic                  o_axi_rready
);

    // Every channel and port uses the same rule: a transfer happens on the
    // rising edge where valid and ready are both high; a valid, once raised,
    // holds with stable payload until that edge (reset and timeout excepted).

    if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("axi_lite_master: DATA_WIDTH must be 32 and TIMEOUT_CYCLES at least 2");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;

    logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;

    assign cmd_hs = i_cmd_valid && (state_q == IDLE);
    assign aw_hs  = awvalid_q && i_axi_awready;
    assign w_hs   = wvalid_q && i_axi_wready;
    assign b_hs   = bready_q && i_axi_bvalid;
    assign ar_hs  = arvalid_q && i_axi_arready;
    assign r_hs   = rready_q && i_axi_rvalid;
    assign rsp_hs = rsp_valid_q && i_rsp_ready;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             waiting, any_hs, timeout;

    assign waiting = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                     (state_q == RD_REQ) || (state_q == RD_DATA);
    assign any_hs  = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    assign timeout = waiting && (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Restarts on request entry and on every channel transfer, so the limit
    // bounds the silence of a single channel rather than the whole access.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (cmd_hs || any_hs) begin
            to_cnt_d = '0;
        end else if (waiting) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;

        case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    we_d    = i_cmd_we;
                    addr_d  = i_cmd_addr;
                    wdata_d = i_cmd_wdata;
                    wstrb_d = i_cmd_wstrb;
                    if (i_cmd_we) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end

            WR_REQ: begin
                // AW and W complete independently; B waits for both.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = WR_RESP;
                end
            end

            WR_RESP: begin
                if (b_hs) begin
                    resp_d      = i_axi_bresp;
                    rdata_d     = '0;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end

            RD_REQ: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end

            RD_DATA: begin
                if (r_hs) begin
                    rdata_d     = i_axi_rdata;
                    resp_d      = i_axi_rresp;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end

            RSP: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        // Bring-up recovery: abandons the outstanding channel and reports DECERR.
        if (timeout) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            aw_done_d   = 1'b0;
            w_done_d    = 1'b0;
            resp_d      = 2'b11;
            rdata_d     = '0;
            rsp_valid_d = 1'b1;
            state_d     = RSP;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
        end
    end

    assign o_cmd_ready   = (state_q == IDLE);
    assign o_busy        = (state_q != IDLE);
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_we      = we_q;
    assign o_rsp_rdata   = rdata_q;
    assign o_rsp_resp    = resp_q;
    assign o_axi_awaddr  = addr_q;
    assign o_axi_awvalid = awvalid_q;
    assign o_axi_wdata   = wdata_q;
    assign o_axi_wstrb   = wstrb_q;
    assign o_axi_wvalid  = wvalid_q;
    assign o_axi_bready  = bready_q;
    assign o_axi_araddr  = addr_q;
    assign o_axi_arvalid = arvalid_q;
    assign o_axi_rready  = rready_q;

endmodule
